// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer and flag controller for the async FIFO.
// Owns the read pointer; derives empty, almost-empty, level, underflow.
module rptr_empty_ctrl #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic                rclr_uflow,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam logic [ADDRSIZE:0] AE_TH =
    ADDRSIZE'(0) + (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] level_next;
  logic              accept;
  logic              rempty_next;
  logic              raempty_next;
  logic              uflow_next;

  // Gray-to-binary of the synchronized write pointer:
  // bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
  end

  // Next pointer, flags and level; a pop is refused while empty.
  always_comb begin
    accept       = rinc & ~rempty;
    rbinnext     = rbin + {{ADDRSIZE{1'b0}}, accept};
    rgraynext    = (rbinnext >> 1) ^ rbinnext;
    level_next   = wbin - rbinnext;
    rempty_next  = (rgraynext == rq2_wptr);
    raempty_next = (level_next <= AE_TH);
    uflow_next   = (rinc & rempty) | (runderflow & ~rclr_uflow);
  end

  // Pointer registers; rptr is driven straight from a flop.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin <= '0;
      rptr <= '0;
    end else begin
      rbin <= rbinnext;
      rptr <= rgraynext;
    end
  end

  // Registered status: empty, almost-empty, level, sticky underflow.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rempty     <= 1'b1;
      raempty    <= 1'b1;
      rlevel     <= '0;
      runderflow <= 1'b0;
    end else begin
      rempty     <= rempty_next;
      raempty    <= raempty_next;
      rlevel     <= level_next;
      runderflow <= uflow_next;
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Bench for rptr_empty_ctrl: directed cases plus random traffic
// against an occupancy model built on total read/write counts.
module tb_rptr_empty_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int TH    = 2;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rinc;
  logic          rclr_uflow;
  logic [AW:0]   rq2_wptr;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic          raempty;
  logic [AW:0]   rlevel;
  logic          runderflow;

  rptr_empty_ctrl #(.ADDRSIZE(AW), .AEMPTY_THRESH(TH)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc),
    .rclr_uflow(rclr_uflow), .rq2_wptr(rq2_wptr),
    .raddr(raddr), .rptr(rptr), .rempty(rempty),
    .raempty(raempty), .rlevel(rlevel),
    .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: totals of entries written and read since reset.
  int w_tot;
  int r_tot;
  int m_level;
  bit m_empty;
  bit m_aempty;
  bit m_uflow;
  bit saw_wrap;
  logic [AW:0] prev_rptr;

  function automatic logic [AW:0] to_gray(int b);
    logic [AW:0] x;
    x = b[AW:0];
    return (x >> 1) ^ x;
  endfunction

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(string tag);
    check({tag, ".rptr"}, 32'(rptr), 32'(to_gray(r_tot)));
    check({tag, ".raddr"}, 32'(raddr), 32'(r_tot % DEPTH));
    check({tag, ".rempty"}, 32'(rempty), 32'(m_empty));
    check({tag, ".raempty"}, 32'(raempty), 32'(m_aempty));
    check({tag, ".rlevel"}, 32'(rlevel), 32'(m_level));
    check({tag, ".uflow"}, 32'(runderflow), 32'(m_uflow));
  endtask

  task automatic model_reset();
    w_tot    = 0;
    r_tot    = 0;
    m_level  = 0;
    m_empty  = 1'b1;
    m_aempty = 1'b1;
    m_uflow  = 1'b0;
  endtask

  // One rclk cycle: drive, clock, update model, compare.
  task automatic step(string tag, bit inc, bit clr, int wadv);
    bit acc;
    rinc       = inc;
    rclr_uflow = clr;
    w_tot      = w_tot + wadv;
    rq2_wptr   = to_gray(w_tot);
    check({tag, ".raddr_pre"}, 32'(raddr), 32'(r_tot % DEPTH));
    @(posedge rclk);
    acc      = inc && !m_empty;
    m_uflow  = (inc && m_empty) || (m_uflow && !clr);
    r_tot    = r_tot + int'(acc);
    m_level  = w_tot - r_tot;
    m_empty  = (m_level == 0);
    m_aempty = (m_level <= TH);
    #1;
    chk_all(tag);
    if (prev_rptr == 5'b10000 && rptr == 5'b00000)
      saw_wrap = 1'b1;
    prev_rptr = rptr;
  endtask

  // Reset asserted between edges; outputs must clear at once.
  task automatic async_reset(string tag);
    @(negedge rclk);
    #2;
    rrst     = 1'b1;
    rinc     = 1'b0;
    rq2_wptr = '0;
    model_reset();
    #1;
    chk_all(tag);
    @(negedge rclk);
    rrst = 1'b0;
    prev_rptr = '0;
  endtask

  initial begin
    int written;
    rrst       = 1'b1;
    rinc       = 1'b0;
    rclr_uflow = 1'b0;
    rq2_wptr   = '0;
    saw_wrap   = 1'b0;
    prev_rptr  = '0;
    model_reset();
    #1;
    chk_all("por");
    @(negedge rclk);
    rrst = 1'b0;

    // Three entries then three pops.
    step("fill3", 1'b0, 1'b0, 3);
    for (int i = 0; i < 3; i++)
      step("pop3", 1'b1, 1'b0, 0);
    check("pop3.rptr_lit", 32'(rptr), 32'd2);

    // Underflow set, set-beats-clear, then clear.
    step("uf_set", 1'b1, 1'b0, 0);
    step("uf_both", 1'b1, 1'b1, 0);
    step("uf_clr", 1'b0, 1'b1, 0);

    // Mid-stream asynchronous reset.
    step("pre_rst", 1'b0, 1'b0, 2);
    async_reset("mid_rst");

    // Full depth then drain.
    step("full", 1'b0, 1'b0, DEPTH);
    check("full.wptr_lit", 32'(rq2_wptr), 32'h18);
    for (int i = 0; i < DEPTH; i++)
      step("drain", 1'b1, 1'b0, 0);

    // Stream 40 entries with interleaved pops, through the wrap.
    written = 0;
    while (written < 40 || m_level > 0) begin
      int wa;
      wa = (written < 40 && (w_tot - r_tot) < DEPTH
            && ($urandom % 2 == 1)) ? 1 : 0;
      written += wa;
      step("stream", ($urandom % 3 != 0), 1'b0, wa);
    end
    check("stream.wrap_seen", 32'(saw_wrap), 32'd1);

    // Last-entry pop coinciding with a write.
    step("lvl1", 1'b0, 1'b0, 1);
    step("popwr", 1'b1, 1'b0, 1);
    step("popwr2", 1'b1, 1'b0, 1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      int wa;
      if ($urandom % 400 == 0) begin
        async_reset("rnd_rst");
      end else begin
        wa = ((w_tot - r_tot) < DEPTH && ($urandom % 2 == 1)) ? 1 : 0;
        step("rnd", ($urandom % 2 == 1), ($urandom % 8 == 0), wa);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
